// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit with stall, ready pulse and cancel
// Results are staged on entry to DONE and committed on the DONE->IDLE edge unless cancelled.
`timescale 1ns/1ps
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_ITER = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]      CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic                 op_div_q, op_div_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic [WIDTH-1:0]     stg_hi_q, stg_hi_d, stg_lo_q, stg_lo_d;
  logic                 stg_dbz_q, stg_dbz_d;
  logic [WIDTH-1:0]     res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic                 res_dbz_q, res_dbz_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   prod_comb;
  logic [WIDTH:0]       rem_sh, diff, mul_sum;
  logic [2*WIDTH-1:0]   div_next, mul_next, iter_next;
  logic [2*WIDTH:0]     fin;

  // Sign fix-up of the unsigned core result; divide-by-zero overrides everything.
  function automatic logic [2*WIDTH:0] finish_res(
    input logic               is_div,
    input logic [2*WIDTH-1:0] raw,
    input logic               neg,
    input logic               rneg,
    input logic [WIDTH-1:0]   divisor,
    input logic [WIDTH-1:0]   dividend_raw
  );
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   r;
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH:0]   res;
    q = raw[WIDTH-1:0];
    r = raw[2*WIDTH-1:WIDTH];
    p = raw;
    if (is_div) begin
      if (divisor == '0) begin
        res = {1'b1, dividend_raw, {WIDTH{1'b1}}};
      end else begin
        if (neg)  q = ~q + ONE_W;
        if (rneg) r = ~r + ONE_W;
        res = {1'b0, r, q};
      end
    end else begin
      if (neg) p = ~p + ONE_2W;
      res = {1'b0, p};
    end
    return res;
  endfunction

  always_comb begin
    a_neg     = ~op[0] & src_a[WIDTH-1];
    b_neg     = ~op[0] & src_b[WIDTH-1];
    mag_a     = a_neg ? (~src_a + ONE_W) : src_a;
    mag_b     = b_neg ? (~src_b + ONE_W) : src_b;
    prod_comb = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};

    // Restoring step: remainder in the upper half, dividend/quotient shifting in the lower half.
    rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, b_q};
    div_next  = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

    // Shift-add step: multiplier consumed from the low end, partial product grows in the high half.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    iter_next = op_div_q ? div_next : mul_next;
  end

  always_comb begin
    state_d   = state_q;
    op_div_d  = op_div_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    a_d       = a_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    stg_hi_d  = stg_hi_q;
    stg_lo_d  = stg_lo_q;
    stg_dbz_d = stg_dbz_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    res_dbz_d = res_dbz_q;
    fin       = '0;

    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          op_div_d = op[1];
          a_d      = src_a;
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          cnt_d    = CNT_INIT;
          if (op[1]) begin
            b_d     = mag_b;
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            state_d = CALC;
          end else if (MUL_ITER == 0) begin
            fin = finish_res(1'b0, prod_comb, a_neg ^ b_neg, 1'b0, mag_b, src_a);
            {stg_dbz_d, stg_hi_d, stg_lo_d} = fin;
            state_d = DONE;
          end else begin
            b_d     = mag_a;
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = iter_next;
        if (cnt_q == '0) begin
          fin = finish_res(op_div_q, iter_next, neg_q, rneg_q, b_q, a_q);
          {stg_dbz_d, stg_hi_d, stg_lo_d} = fin;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!cancel) begin
          res_hi_d  = stg_hi_q;
          res_lo_d  = stg_lo_q;
          res_dbz_d = stg_dbz_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cancel) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_div_q  <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      a_q       <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      stg_hi_q  <= '0;
      stg_lo_q  <= '0;
      stg_dbz_q <= 1'b0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
      res_dbz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_div_q  <= op_div_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      a_q       <= a_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      stg_hi_q  <= stg_hi_d;
      stg_lo_q  <= stg_lo_d;
      stg_dbz_q <= stg_dbz_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      res_dbz_q <= res_dbz_d;
    end
  end

  // During the ready cycle the staged result is already visible so hilo can capture it.
  assign ready       = (state_q == DONE) & ~cancel;
  assign busy        = ((state_q == IDLE) & start & ~cancel) | (state_q == CALC);
  assign result_hi   = ready ? stg_hi_q  : res_hi_q;
  assign result_lo   = ready ? stg_lo_q  : res_lo_q;
  assign div_by_zero = ready ? stg_dbz_q : res_dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic model
`timescale 1ns/1ps
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        start0 = 1'b0;
  logic        cancel = 1'b0;
  logic        cancel0 = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, ready, dbz;
  logic [31:0] hi, lo;
  logic        busy0, ready0, dbz0;
  logic [31:0] hi0, lo0;

  int total = 0;
  int bad = 0;
  int dut_pulses = 0;

  bit          m_active = 0;
  int          m_k = 0;
  logic [64:0] m_exp = '0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dbz = 1'b0;
  localparam int LAT = 33;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .MUL_ITER(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .busy(busy), .ready(ready), .result_hi(hi), .result_lo(lo),
    .div_by_zero(dbz));

  muldiv_unit #(.WIDTH(32), .MUL_ITER(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel0), .busy(busy0), .ready(ready0), .result_hi(hi0), .result_lo(lo0),
    .div_by_zero(dbz0));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {div_by_zero, hi, lo} from plain arithmetic on the operands.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    logic [63:0] p;
    logic [31:0] q, r;
    logic [64:0] res;
    sa = a;
    sb = b;
    case (o)
      2'd0: begin p = longint'(sa) * longint'(sb); res = {1'b0, p}; end
      2'd1: begin p = {32'b0, a} * {32'b0, b}; res = {1'b0, p}; end
      2'd2: begin
        if (b == 0) res = {1'b1, a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = {1'b0, 32'h0, 32'h80000000};
        else begin q = sa / sb; r = sa % sb; res = {1'b0, r, q}; end
      end
      default: begin
        if (b == 0) res = {1'b1, a, 32'hFFFFFFFF};
        else begin q = a / b; r = a % b; res = {1'b0, r, q}; end
      end
    endcase
    return res;
  endfunction

  // Cycle-level expectation: accept cycle 0, ready in cycle LAT, results visible from the ready cycle.
  always @(negedge clk) begin
    logic exp_busy, exp_ready;
    exp_busy  = 1'b0;
    exp_ready = 1'b0;
    if (ready) dut_pulses++;
    if (!rst) begin
      m_active = 0;
      m_hi = '0; m_lo = '0; m_dbz = 1'b0;
      exp_busy = start && !cancel;
    end else if (!m_active) begin
      exp_busy = start && !cancel;
      if (exp_busy) begin
        m_active = 1;
        m_k = 0;
        m_exp = model(op, src_a, src_b);
      end
    end else begin
      m_k++;
      if (m_k == LAT) begin
        m_active = 0;
        if (!cancel) begin
          exp_ready = 1'b1;
          {m_dbz, m_hi, m_lo} = m_exp;
        end
      end else begin
        exp_busy = 1'b1;
        if (cancel) m_active = 0;
      end
    end
    chk("busy", busy, exp_busy);
    chk("ready", ready, exp_ready);
    chk("result_hi", hi, m_hi);
    chk("result_lo", lo, m_lo);
    chk("div_by_zero", dbz, m_dbz);
  end

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int cancel_k, input bit hold, input int last_k, output int rk);
    rk = -1;
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b; cancel = (cancel_k == 0);
    for (int k = 0; k <= last_k; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        start = hold; cancel = (k == cancel_k);
        src_a = $urandom; src_b = $urandom; op = 2'($urandom);
      end
      @(negedge clk);
      if (ready && rk < 0) rk = k;
      if (cancel_k == 0 && k == 0) chk("busy_cancel_start", busy, 1'b0);
      if (cancel_k > 0 && k == cancel_k + 1) chk("busy_after_cancel", busy, 1'b0);
    end
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
  endtask

  task automatic expect_res(input string name, input int rk, input int erk,
                            input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    chk({name, "_cycle"}, rk, erk);
    chk({name, "_hi"}, hi, ehi);
    chk({name, "_lo"}, lo, elo);
    chk({name, "_dbz"}, dbz, edbz);
  endtask

  task automatic do_op0(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    @(posedge clk); #1;
    start0 = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    chk({name, "_ready_c0"}, ready0, 1'b0);
    chk({name, "_busy_c0"}, busy0, 1'b1);
    @(posedge clk); #1;
    start0 = 1'b0;
    @(negedge clk);
    chk({name, "_ready_c1"}, ready0, 1'b1);
    chk({name, "_busy_c1"}, busy0, 1'b0);
    chk({name, "_hi"}, hi0, ehi);
    chk({name, "_lo"}, lo0, elo);
    chk({name, "_dbz"}, dbz0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_ready_c2"}, ready0, 1'b0);
    chk({name, "_hold_lo"}, lo0, elo);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int rk;
    int pulses;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", ready, 1'b0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_dbz", dbz, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;

    do_op(2'd2, 32'hFFFFFFF9, 32'h00000002, -1, 0, 34, rk);
    expect_res("div_neg7_2", rk, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    do_op(2'd3, 32'hFFFFFFFF, 32'h00000010, -1, 0, 34, rk);
    expect_res("divu_big_16", rk, 33, 32'h0000000F, 32'h0FFFFFFF, 1'b0);
    do_op(2'd3, 32'd5, 32'd0, -1, 0, 34, rk);
    expect_res("divu_5_0", rk, 33, 32'h00000005, 32'hFFFFFFFF, 1'b1);
    do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, -1, 0, 34, rk);
    expect_res("div_minneg_m1", rk, 33, 32'h0, 32'h80000000, 1'b0);
    do_op(2'd0, 32'hFFFFFFFF, 32'h00000002, -1, 0, 34, rk);
    expect_res("mult_m1_2", rk, 33, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    do_op(2'd1, 32'hFFFFFFFF, 32'h00000002, -1, 0, 34, rk);
    expect_res("multu_big_2", rk, 33, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    do_op(2'd2, 32'd100, 32'hFFFFFFF9, -1, 0, 34, rk);
    expect_res("div_100_m7", rk, 33, 32'h00000002, 32'hFFFFFFF2, 1'b0);
    do_op(2'd3, 32'd5, 32'd0, -1, 0, 34, rk);
    do_op(2'd3, 32'd9, 32'd3, -1, 0, 34, rk);
    expect_res("divu_9_3", rk, 33, 32'h0, 32'h3, 1'b0);

    do_op(2'd2, 32'd100, 32'd7, 10, 0, 36, rk);
    expect_res("cancel_calc", rk, -1, 32'h0, 32'h3, 1'b0);
    do_op(2'd2, 32'd100, 32'd7, 0, 0, 36, rk);
    expect_res("cancel_start", rk, -1, 32'h0, 32'h3, 1'b0);
    do_op(2'd1, 32'd7, 32'd6, 33, 0, 35, rk);
    expect_res("cancel_done", rk, -1, 32'h0, 32'h3, 1'b0);

    pulses = dut_pulses;
    do_op(2'd3, 32'd100, 32'd7, -1, 1, 33, rk);
    repeat (5) @(negedge clk);
    expect_res("held_start", rk, 33, 32'h2, 32'he, 1'b0);
    chk("held_start_pulses", dut_pulses - pulses, 1);

    do_op(2'd3, 32'd1000, 32'd3, -1, 0, 15, rk);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_ready", ready, 1'b0);
    chk("midreset_hi", hi, 32'h0);
    chk("midreset_lo", lo, 32'h0);
    chk("midreset_dbz", dbz, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    do_op(2'd3, 32'd9, 32'd3, -1, 0, 34, rk);
    expect_res("after_reset_divu", rk, 33, 32'h0, 32'h3, 1'b0);

    do_op0("mul0_mult", 2'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE);
    do_op0("mul0_multu", 2'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
